// File: rtl/gemm_pkg.sv
// gemm_pkg: shared constants for the GEMM tile stream sequencer.
//   - buffer geometry (cores, weight/source/destination depths)
//   - derived address widths
//   - stream_sched FSM state encoding (also exported on the debug port)
//   - one-hot helper used to pick the per-core weight write strobe
package gemm_pkg;

    localparam int NCORE     = 4;
    localparam int PRM_DEPTH = 8;
    localparam int SRC_DEPTH = 32;
    localparam int DST_DEPTH = 16;

    localparam int CORE_AW = $clog2(NCORE);
    localparam int PRM_AW  = $clog2(PRM_DEPTH);
    localparam int SRC_AW  = $clog2(SRC_DEPTH);
    localparam int DST_AW  = $clog2(DST_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MATW  = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_KICK  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_HOLD  = 3'd6;

    function automatic logic [NCORE-1:0] core_onehot(input logic [CORE_AW-1:0] idx);
        logic [NCORE-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// beat_counter: wrap-around index counter for one buffer dimension.
//   clk, reset : clock, asynchronous active-high reset
//   en         : advance by one (wraps DEPTH-1 -> 0)
//   clr        : synchronous clear, wins over en
//   cnt        : current index
//   last       : cnt is at DEPTH-1 (the next advance wraps)
module beat_counter #(
    parameter int DEPTH = 8,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == W'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/stream_sched.sv
// stream_sched: phase sequencer for the 4-core GEMM tile.
//   clk, reset            : stream clock, asynchronous active-high reset
//   matw, run             : mode levels from the control registers
//   src_valid / src_ready : slave stream handshake (weights or source data)
//   dst_valid / dst_ready : master stream handshake (results)
//   src_v, src_a          : source buffer write strobe / address
//   prm_v, prm_a          : per-core one-hot weight write strobe / address
//   dst_v, dst_a          : destination read advance / address presented
//   s_init, s_fin         : start pulse to / done pulse from execute controller
//   batch_cnt             : completed batches since reset (wraps)
//   state                 : FSM state for debug
module stream_sched
    import gemm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              matw,
    input  logic              run,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              dst_valid,
    input  logic              dst_ready,
    output logic              src_v,
    output logic [SRC_AW-1:0] src_a,
    output logic [NCORE-1:0]  prm_v,
    output logic [PRM_AW-1:0] prm_a,
    output logic              dst_v,
    output logic [DST_AW-1:0] dst_a,
    output logic              s_init,
    input  logic              s_fin,
    output logic [15:0]       batch_cnt,
    output logic [2:0]        state
);

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [CORE_AW-1:0] core_idx;
    logic               w_last;
    logic               core_last;
    logic               s_last;
    logic               d_last;
    logic               matw_beat;
    logic               load_beat;
    logic               drain_beat;
    logic               cnt_clr;

    // Handshakes are qualified by the mode bit itself, so the cycle in which
    // the bit drops (abort) never accepts a beat or emits a pulse.
    assign src_ready  = ((state_q == S_MATW) && matw) || ((state_q == S_LOAD) && run);
    assign matw_beat  = (state_q == S_MATW) && matw && src_valid;
    assign load_beat  = (state_q == S_LOAD) && run && src_valid;
    assign dst_valid  = (state_q == S_DRAIN) && run;
    assign drain_beat = dst_valid && dst_ready;

    assign src_v  = load_beat;
    assign prm_v  = matw_beat ? core_onehot(core_idx) : '0;
    assign dst_v  = drain_beat;
    assign s_init = (state_q == S_KICK) && run;
    assign state  = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (matw)
                    state_d = S_MATW;
                else if (run)
                    state_d = S_LOAD;
            end
            S_MATW: begin
                if (!matw)
                    state_d = S_IDLE;
                else if (matw_beat && w_last && core_last)
                    state_d = S_HOLD;
            end
            S_LOAD: begin
                if (!run)
                    state_d = S_IDLE;
                else if (load_beat && s_last)
                    state_d = S_KICK;
            end
            S_KICK: begin
                state_d = run ? S_EXEC : S_IDLE;
            end
            S_EXEC: begin
                if (!run)
                    state_d = S_IDLE;
                else if (s_fin)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // A drain beat implies run is still high, so the batch loops
                // straight back into LOAD.
                if (!run)
                    state_d = S_IDLE;
                else if (drain_beat && d_last)
                    state_d = S_LOAD;
            end
            S_HOLD: begin
                if (!matw)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every path back to IDLE (abort or normal) leaves all indices at zero;
    // completed phases wrap to zero on their own.
    assign cnt_clr = (state_d == S_IDLE);

    beat_counter #(.DEPTH(PRM_DEPTH)) u_w_idx (
        .clk   (clk),
        .reset (reset),
        .en    (matw_beat),
        .clr   (cnt_clr),
        .cnt   (prm_a),
        .last  (w_last)
    );

    beat_counter #(.DEPTH(NCORE)) u_core_idx (
        .clk   (clk),
        .reset (reset),
        .en    (matw_beat && w_last),
        .clr   (cnt_clr),
        .cnt   (core_idx),
        .last  (core_last)
    );

    beat_counter #(.DEPTH(SRC_DEPTH)) u_s_idx (
        .clk   (clk),
        .reset (reset),
        .en    (load_beat),
        .clr   (cnt_clr),
        .cnt   (src_a),
        .last  (s_last)
    );

    beat_counter #(.DEPTH(DST_DEPTH)) u_d_idx (
        .clk   (clk),
        .reset (reset),
        .en    (drain_beat),
        .clr   (cnt_clr),
        .cnt   (dst_a),
        .last  (d_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            batch_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (drain_beat && d_last)
                batch_cnt <= batch_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_stream_sched.sv
module tb_stream_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        matw;
    logic        run;
    logic        src_valid;
    logic        src_ready;
    logic        dst_valid;
    logic        dst_ready;
    logic        src_v;
    logic [4:0]  src_a;
    logic [3:0]  prm_v;
    logic [2:0]  prm_a;
    logic        dst_v;
    logic [3:0]  dst_a;
    logic        s_init;
    logic        s_fin;
    logic [15:0] batch_cnt;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    stream_sched dut (
        .clk       (clk),
        .reset     (reset),
        .matw      (matw),
        .run       (run),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .src_v     (src_v),
        .src_a     (src_a),
        .prm_v     (prm_v),
        .prm_a     (prm_a),
        .dst_v     (dst_v),
        .dst_a     (dst_a),
        .s_init    (s_init),
        .s_fin     (s_fin),
        .batch_cnt (batch_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] in;   // {matw, run, src_valid, dst_ready, s_fin}
        logic [2:0] st;
        logic       rdy;
        logic       sv;
        logic [4:0] sa;
        logic [3:0] pv;
        logic [2:0] pa;
        logic       dv;
        logic       si;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [4:0] in, input logic [2:0] st, input logic rdy,
                                input logic sv, input logic [4:0] sa, input logic [3:0] pv,
                                input logic [2:0] pa, input logic dv, input logic si);
        vec_t v;
        v.in = in; v.st = st; v.rdy = rdy; v.sv = sv; v.sa = sa;
        v.pv = pv; v.pa = pa; v.dv = dv; v.si = si;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic m, input logic r, input logic sv, input logic dr, input logic fin);
        matw = m; run = r; src_valid = sv; dst_ready = dr; s_fin = fin;
        #1;
    endtask

    function automatic logic [39:0] obs();
        return {state, src_ready, src_v, src_a, prm_v, prm_a, dst_valid, dst_v, dst_a, s_init, batch_cnt};
    endfunction

    // Full batch starting in the first LOAD cycle; ends in the first LOAD
    // cycle of the following batch.
    task automatic do_batch(input int stall_at, input logic [15:0] exp_batch);
        int d;
        int stalls;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            check("load_beat", {src_ready, src_v, src_a}, {1'b1, 1'b1, 5'(i)});
            cyc();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("kick", {state, s_init, src_ready}, {3'd3, 1'b1, 1'b0});
        cyc();
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("exec_wait", {state, s_init, src_ready, dst_valid}, {3'd4, 3'b000});
            cyc();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        d = 0;
        stalls = 0;
        for (int k = 0; k < 16 + ((stall_at >= 0) ? 5 : 0); k++) begin
            if (d == stall_at && stalls < 5) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                check("drain_stall", {dst_valid, dst_v, dst_a}, {1'b1, 1'b0, 4'(d)});
                stalls++;
            end else begin
                drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                check("drain_beat", {state, dst_valid, dst_v, dst_a}, {3'd5, 1'b1, 1'b1, 4'(d)});
                d++;
            end
            cyc();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("reload", {state, src_ready, batch_cnt}, {3'd2, 1'b1, exp_batch});
    endtask

    // Reference model state (phase code, beats taken in this phase, batches)
    int          ms;
    int          mbeats;
    logic [15:0] mbatch;

    initial begin
        reset = 1'b1;
        matw = 1'b0; run = 1'b0; src_valid = 1'b0; dst_ready = 1'b0; s_fin = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // ---------------- table-driven short sequences ----------------
        tbl[0]  = mk(5'b00000, 3'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[1]  = mk(5'b11000, 3'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[2]  = mk(5'b10100, 3'd1, 1'b1, 1'b0, 5'd0, 4'b0001, 3'd0, 1'b0, 1'b0);
        tbl[3]  = mk(5'b10100, 3'd1, 1'b1, 1'b0, 5'd0, 4'b0001, 3'd1, 1'b0, 1'b0);
        tbl[4]  = mk(5'b10000, 3'd1, 1'b1, 1'b0, 5'd0, 4'b0000, 3'd2, 1'b0, 1'b0);
        tbl[5]  = mk(5'b00100, 3'd1, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd2, 1'b0, 1'b0);
        tbl[6]  = mk(5'b00001, 3'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[7]  = mk(5'b01100, 3'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[8]  = mk(5'b01100, 3'd2, 1'b1, 1'b1, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[9]  = mk(5'b01100, 3'd2, 1'b1, 1'b1, 5'd1, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[10] = mk(5'b00100, 3'd2, 1'b0, 1'b0, 5'd2, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[11] = mk(5'b00000, 3'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[12] = mk(5'b01000, 3'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[13] = mk(5'b01000, 3'd2, 1'b1, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[14] = mk(5'b00000, 3'd2, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);
        tbl[15] = mk(5'b00000, 3'd0, 1'b0, 1'b0, 5'd0, 4'b0000, 3'd0, 1'b0, 1'b0);

        check("reset_state", {obs()}, 40'h0);
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            check($sformatf("table_row%0d", i),
                  {state, src_ready, src_v, src_a, prm_v, prm_a, dst_valid, s_init},
                  {tbl[i].st, tbl[i].rdy, tbl[i].sv, tbl[i].sa, tbl[i].pv, tbl[i].pa, tbl[i].dv, tbl[i].si});
            cyc();
        end

        // ---------------- full matrix write ----------------
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            check("matw_beat", {state, prm_v, prm_a}, {3'd1, 4'(1 << (i / 8)), 3'(i % 8)});
            cyc();
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_enter", {state, src_ready, prm_v}, {3'd6, 1'b0, 4'b0000});
        cyc();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_stay", {state, src_ready, prm_v}, {3'd6, 1'b0, 4'b0000});
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold_exit", {state, prm_a}, {3'd0, 3'd0});

        // ---------------- three continuous batches ----------------
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        do_batch(7, 16'd1);
        do_batch(-1, 16'd2);
        do_batch(12, 16'd3);

        // ---------------- abort during LOAD ----------------
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_no_beat", {src_v, src_ready, src_a}, {1'b0, 1'b0, 5'd12});
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_idle", {state, s_init, src_a, batch_cnt}, {3'd0, 1'b0, 5'd0, 16'd3});
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("restart_addr", {state, src_v, src_a}, {3'd2, 1'b1, 5'd0});
        cyc();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // ---------------- async reset mid-DRAIN ----------------
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_reset_drain", {state, dst_a, batch_cnt}, {3'd5, 4'd3, 16'd3});
        reset = 1'b1;
        #1;
        check("async_reset", obs(), 40'h0);
        cyc();
        reset = 1'b0;

        // ---------------- randomized run against reference model ----------------
        begin
            logic        r_matw;
            logic        r_run;
            logic        sv;
            logic        dr;
            logic        fin;
            logic        e_rdy;
            logic        beat;
            logic        e_dv;
            logic [4:0]  e_sa;
            logic [3:0]  e_pv;
            logic [2:0]  e_pa;
            logic [3:0]  e_da;
            logic [39:0] exp;
            ms = 0; mbeats = 0; mbatch = 16'd0;
            r_matw = 1'b0; r_run = 1'b1;
            for (int c = 0; c < 6000; c++) begin
                if ($urandom_range(0, 299) == 0) r_run = ~r_run;
                if ($urandom_range(0, 199) == 0) r_matw = ~r_matw;
                sv  = ($urandom_range(0, 3) != 0);
                dr  = ($urandom_range(0, 9) < 7);
                fin = ($urandom_range(0, 9) == 0);
                drive(r_matw, r_run, sv, dr, fin);

                e_rdy = (ms == 1 && r_matw) || (ms == 2 && r_run);
                beat  = e_rdy && sv;
                e_dv  = (ms == 5) && r_run;
                e_sa  = (ms == 2) ? 5'(mbeats) : 5'd0;
                e_pa  = (ms == 1) ? 3'(mbeats % 8) : 3'd0;
                e_pv  = (ms == 1 && beat) ? 4'(1 << (mbeats / 8)) : 4'd0;
                e_da  = (ms == 5) ? 4'(mbeats) : 4'd0;
                exp = {3'(ms), e_rdy, (ms == 2) && beat, e_sa, e_pv, e_pa,
                       e_dv, e_dv && dr, e_da, (ms == 3) && r_run, mbatch};
                check("random_cycle", obs(), exp);

                case (ms)
                    0: begin
                        mbeats = 0;
                        if (r_matw) ms = 1;
                        else if (r_run) ms = 2;
                    end
                    1: if (!r_matw) begin ms = 0; mbeats = 0; end
                       else if (beat) begin
                           mbeats++;
                           if (mbeats == 32) begin ms = 6; mbeats = 0; end
                       end
                    2: if (!r_run) begin ms = 0; mbeats = 0; end
                       else if (beat) begin
                           mbeats++;
                           if (mbeats == 32) begin ms = 3; mbeats = 0; end
                       end
                    3: ms = r_run ? 4 : 0;
                    4: if (!r_run) ms = 0;
                       else if (fin) begin ms = 5; mbeats = 0; end
                    5: if (!r_run) begin ms = 0; mbeats = 0; end
                       else if (dr) begin
                           mbeats++;
                           if (mbeats == 16) begin ms = 2; mbeats = 0; mbatch = mbatch + 16'd1; end
                       end
                    6: if (!r_matw) ms = 0;
                    default: ms = 0;
                endcase
                cyc();
            end
            check("random_batches_seen", {31'd0, mbatch != 16'd0}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_sched.md
Name: stream_sched

Overview:
- Phase sequencer for the 4-core GEMM tile.
- Steers the slave AXI-Stream into the per-core weight RAMs during matrix-write and into the source buffer during run.
- Kicks the execute controller with `s_init`, waits for `s_fin`, then drains the destination buffer onto the master AXI-Stream.
- Sits between the AXI-Lite control bits (`matw`, `run`) and the src/param/dst buffers.

Parameters:
- NCORE, 4, number of cores; width of `prm_v`
- PRM_DEPTH, 8, weight words per core; `prm_a` width = clog2 = 3
- SRC_DEPTH, 32, source words per batch; `src_a` width = 5
- DST_DEPTH, 16, result words per batch; `dst_a` width = 4

Ports:
- clk  in  1  stream clock
- reset  in  1  asynchronous, active-high reset
- matw  in  1  level: matrix-write mode request
- run  in  1  level: batch-run mode request
- src_valid  in  1  slave stream TVALID
- src_ready  out  1  slave stream TREADY
- dst_valid  out  1  master stream TVALID
- dst_ready  in  1  master stream TREADY
- src_v  out  1  source buffer write strobe
- src_a  out  5  source buffer write address
- prm_v  out  NCORE  one-hot weight write strobe per core
- prm_a  out  3  weight write address
- dst_v  out  1  destination read advance (beat accepted)
- dst_a  out  4  destination read address of beat currently presented
- s_init  out  1  one-cycle start pulse to execute controller
- s_fin  in  1  one-cycle done pulse from execute controller
- batch_cnt  out  16  completed batches since reset; wraps at 0xFFFF->0
- state  out  3  FSM state, debug

Behaviour:
- Reset (async, reset=1): state=IDLE, all counters 0; src_ready, dst_valid, src_v, prm_v, dst_v, s_init = 0; batch_cnt=0.
- States:
  - IDLE=0
  - MATW=1
  - LOAD=2
  - KICK=3
  - EXEC=4
  - DRAIN=5
  - HOLD=6 (wait for the mode bit to drop).
- IDLE:
  - matw=1 -> MATW; else run=1 -> LOAD.
  - matw has priority when both are high.
- MATW:
  - src_ready=1.
  - Each beat (src_valid & src_ready): prm_v = onehot(core_idx), prm_a = w_idx, combinational with the beat.
  - w_idx increments 0..PRM_DEPTH-1, then wraps to 0 and core_idx increments.
  - Beat NCORE*PRM_DEPTH-1 (31) -> HOLD.
- LOAD:
  - src_ready=1; each beat gives src_v=1, src_a=s_idx; s_idx increments.
  - Beat SRC_DEPTH-1 -> KICK; s_idx clears.
- KICK: s_init=1 for exactly one cycle -> EXEC.
- EXEC:
  - src_ready=0; wait for s_fin.
  - s_fin -> DRAIN, d_idx=0.
  - An s_fin arriving outside EXEC is ignored.
- DRAIN:
  - dst_valid=1, dst_a=d_idx.
  - On dst_ready: dst_v=1 and d_idx increments.
  - dst_valid stays high while dst_ready is low; dst_a is stable during the stall.
  - Beat DST_DEPTH-1: batch_cnt increments, then -> LOAD if run=1, else IDLE.
- HOLD: all strobes 0; -> IDLE when matw=0. This prevents re-writing weights while the bit stays set.
- Abort:
  - matw falling in MATW -> IDLE next cycle; counters clear and partial weights stay written.
  - run falling in LOAD, KICK, EXEC or DRAIN -> IDLE next cycle; no batch_cnt increment.
  - Abort is needed because downstream controllers reset on ~run.
- Strobe timing: src_v, prm_v and dst_v are combinational from the handshake, so latency is 0. Addresses are registered counters.
- Zero-cycle bubbles:
  - Back-to-back beats are accepted every cycle.
  - The LOAD->KICK transition takes 1 cycle.
  - The DRAIN->LOAD transition takes 1 cycle, and src_ready is high in the first LOAD cycle.
- Async reset mid-operation: immediate return to reset values; no partial pulses.

Decomposition:
- Package gemm_pkg holds:
  - state encoding localparams
  - NCORE, PRM_DEPTH, SRC_DEPTH, DST_DEPTH defaults
  - derived address widths
- Sub-module beat_counter: parameterised wrap counter with en, clr and last outputs. It is instantiated for w_idx, core_idx, s_idx and d_idx.

Test Plan:
- Matrix write: matw=1, 32 back-to-back beats -> prm_v sequence 0001 x8 (prm_a 0..7), 0010 x8, 0100 x8, 1000 x8; state=HOLD; matw=0 -> IDLE.
- Single batch: run=1, 32 beats -> src_a 0..31, s_init pulse 1 cycle after beat 31; s_fin after 50 cycles -> 16 dst beats with dst_a 0..15; batch_cnt=1.
- Backpressure: in DRAIN, hold dst_ready=0 for 5 cycles at d_idx=7 -> dst_valid=1, dst_a=7 stable, no dst_v; release -> resumes at 7.
- Continuous run: run held through 3 batches -> batch_cnt=3, LOAD re-entered with src_ready=1 one cycle after last dst beat.
- Abort: drop run at LOAD beat 12 -> IDLE next cycle, no s_init, batch_cnt unchanged; new run restarts at src_a=0.
- Priority and reset: matw=run=1 in IDLE -> MATW; assert reset mid-DRAIN -> all outputs 0 asynchronously, batch_cnt=0.
